// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Brief   : Two-port arbiter in front of a single-port data memory; one
//           registered access per request, answered by a one-cycle response.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int DEPTH      = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [1:0]  c_idle   = 2'd0;
  localparam logic [1:0]  c_access = 2'd1;
  localparam logic [1:0]  c_resp   = 2'd2;
  localparam logic [29:0] c_depth  = 30'(DEPTH);

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic        r_owner;
  logic        r_we;
  logic        r_last_winner;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        w_tie_to_1;
  logic        w_pick1;
  logic        w_any_req;
  logic        w_in_range;

  // On a tie, round-robin hands the grant to whichever port did not win last.
  generate
    if (FIXED_PRIO) begin : g_fixed_prio
      assign w_tie_to_1 = 1'b0;
    end else begin : g_round_robin
      assign w_tie_to_1 = ~r_last_winner;
    end
  endgenerate

  assign w_any_req  = m0_req | m1_req;
  assign w_pick1    = m1_req & (~m0_req | w_tie_to_1);
  assign w_in_range = (r_addr[31:2] < c_depth);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:   if (w_any_req) w_next_state = c_access;
      c_access: w_next_state = c_resp;
      c_resp:   w_next_state = c_idle;
      default:  w_next_state = c_idle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner       <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_err         <= 1'b0;
      r_last_winner <= 1'b1;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_any_req) begin
            r_owner <= w_pick1;
            r_we    <= w_pick1 ? m1_we    : m0_we;
            r_addr  <= w_pick1 ? m1_addr  : m0_addr;
            r_wdata <= w_pick1 ? m1_wdata : m0_wdata;
          end
        end
        c_access: begin
          r_rdata       <= (w_in_range && !r_we) ? mem_rdata : '0;
          r_err         <= ~w_in_range;
          r_last_winner <= r_owner;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    mem_we    = 1'b0;
    case (r_state)
      c_access: begin
        m0_gnt = ~r_owner;
        m1_gnt = r_owner;
        mem_we = r_we & w_in_range;
      end
      c_resp: begin
        m0_rvalid = ~r_owner;
        m1_rvalid = r_owner;
      end
      default: ;
    endcase
  end

  assign busy      = (r_state != c_idle);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign m0_rdata  = r_rdata;
  assign m1_rdata  = r_rdata;
  assign m0_err    = r_err;
  assign m1_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_arbiter
// Brief   : Directed bench for dmem_arbiter (round-robin and fixed-priority).
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        gnt   [2];
  logic        rvalid[2];
  logic [31:0] rdata [2];
  logic        err   [2];
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        busy;

  logic        b_req   [2];
  logic        b_gnt   [2];
  logic        b_rvalid[2];
  logic [31:0] b_rdata [2];
  logic        b_err   [2];
  logic [31:0] b_mem_addr;
  logic [31:0] b_mem_wdata;
  logic        b_mem_we;
  logic        b_busy;

  logic [31:0] mem [0:31];

  int checks = 0;
  int fails  = 0;

  dmem_arbiter #(.DEPTH(32), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_gnt(gnt[0]), .m0_rvalid(rvalid[0]), .m0_rdata(rdata[0]), .m0_err(err[0]),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_gnt(gnt[1]), .m1_rvalid(rvalid[1]), .m1_rdata(rdata[1]), .m1_err(err[1]),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  dmem_arbiter #(.DEPTH(32), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_req(b_req[0]), .m0_we(1'b0), .m0_addr(32'h0), .m0_wdata(32'h0),
    .m0_gnt(b_gnt[0]), .m0_rvalid(b_rvalid[0]), .m0_rdata(b_rdata[0]), .m0_err(b_err[0]),
    .m1_req(b_req[1]), .m1_we(1'b0), .m1_addr(32'h4), .m1_wdata(32'h0),
    .m1_gnt(b_gnt[1]), .m1_rvalid(b_rvalid[1]), .m1_rdata(b_rdata[1]), .m1_err(b_err[1]),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
    .mem_rdata(32'h0BEE_F000), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: writes land on the low index bits so a stray out-of-range
  // write corrupts a visible word; out-of-range reads return a poison value.
  assign mem_rdata = (mem_addr[31:2] < 30'd32) ? mem[mem_addr[6:2]] : 32'hBAD0_BAD0;
  always @(posedge clk) if (mem_we) mem[mem_addr[6:2]] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Single-requester access on the round-robin instance; starts and ends at a
  // falling edge with the arbiter idle.
  task automatic xact(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err, input logic exp_mwe);
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
    @(negedge clk);
    check("gnt_owner", 32'(gnt[p]), 32'd1);
    check("gnt_other", 32'(gnt[1-p]), 32'd0);
    check("mem_we", 32'(mem_we), 32'(exp_mwe));
    check("mem_word", 32'(mem_addr[31:2]), 32'(a[31:2]));
    req[p] = 1'b0;
    @(negedge clk);
    check("rvalid_owner", 32'(rvalid[p]), 32'd1);
    check("rvalid_other", 32'(rvalid[1-p]), 32'd0);
    check("gnt_in_resp", 32'(gnt[p]), 32'd0);
    check("rdata", rdata[p], exp_rd);
    check("err", 32'(err[p]), 32'(exp_err));
    @(negedge clk);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0; b_req[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt0", 32'(gnt[0]), 32'd0);
    check("rst_rvalid1", 32'(rvalid[1]), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rdata", rdata[0], 32'd0);
    reset = 1'b1;

    // Write then read back through port 0, plus a misaligned read of the same word.
    xact(0, 1'b1, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
    check("mem_word2", mem[2], 32'hDEAD_BEEF);
    xact(0, 1'b0, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    xact(0, 1'b0, 32'hB, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Loader preloads word 5 and reads it back; port 0 must stay silent.
    xact(1, 1'b1, 32'h14, 32'h0000_1234, 32'h0, 1'b0, 1'b1);
    xact(1, 1'b0, 32'h17, 32'h0, 32'h0000_1234, 1'b0, 1'b0);

    // Both ports held: alternation starting with port 0 (port 1 won last).
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h8;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h14;
    for (int k = 0; k < 4; k++) begin
      int e;
      e = k % 2;
      @(negedge clk);
      check("rr_gnt", 32'(gnt[e]), 32'd1);
      check("rr_gnt_other", 32'(gnt[1-e]), 32'd0);
      check("rr_busy_access", 32'(busy), 32'd1);
      @(negedge clk);
      check("rr_rvalid", 32'(rvalid[e]), 32'd1);
      check("rr_rdata", rdata[e], (e == 0) ? 32'hDEAD_BEEF : 32'h0000_1234);
      check("rr_busy_resp", 32'(busy), 32'd1);
      if (k == 3) begin
        req[0] = 1'b0; req[1] = 1'b0;
      end
      @(negedge clk);
      check("rr_busy_idle", 32'(busy), 32'd0);
    end

    // Out-of-range accesses from port 1 leave memory untouched.
    xact(0, 1'b1, 32'h0, 32'hA5A5_0000, 32'h0, 1'b0, 1'b1);
    xact(0, 1'b1, 32'hC, 32'h0000_1111, 32'h0, 1'b0, 1'b1);
    xact(1, 1'b1, 32'h80, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    check("oor_word0", mem[0], 32'hA5A5_0000);
    xact(1, 1'b0, 32'h80, 32'h0, 32'h0, 1'b1, 1'b0);
    xact(1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1, 1'b0);
    xact(0, 1'b0, 32'h0, 32'h0, 32'hA5A5_0000, 1'b0, 1'b0);

    // Reset asserted during a write access.
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'hC; wdata[0] = 32'h9999_9999;
    @(negedge clk);
    check("rst5_gnt", 32'(gnt[0]), 32'd1);
    check("rst5_mem_we_pre", 32'(mem_we), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rst5_mem_we", 32'(mem_we), 32'd0);
    check("rst5_gnt_async", 32'(gnt[0]), 32'd0);
    check("rst5_busy", 32'(busy), 32'd0);
    req[0] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst5_no_rvalid", 32'(rvalid[0]), 32'd0);
    end
    check("rst5_word3", mem[3], 32'h0000_1111);
    reset = 1'b1;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'hC;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h14;
    @(negedge clk);
    check("rst5_tie_gnt0", 32'(gnt[0]), 32'd1);
    check("rst5_tie_gnt1", 32'(gnt[1]), 32'd0);
    req[0] = 1'b0;
    @(negedge clk);
    check("rst5_rdata", rdata[0], 32'h0000_1111);
    @(negedge clk);
    @(negedge clk);
    check("rst5_then_gnt1", 32'(gnt[1]), 32'd1);
    req[1] = 1'b0;
    @(negedge clk);
    check("rst5_rdata1", rdata[1], 32'h0000_1234);
    @(negedge clk);

    // Fixed priority: port 0 keeps winning until it drops its request.
    b_req[0] = 1'b1; b_req[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("fp_gnt0", 32'(b_gnt[0]), 32'd1);
      check("fp_gnt1", 32'(b_gnt[1]), 32'd0);
      if (k == 2) b_req[0] = 1'b0;
      @(negedge clk);
      check("fp_rvalid0", 32'(b_rvalid[0]), 32'd1);
      @(negedge clk);
    end
    @(negedge clk);
    check("fp_gnt1_after", 32'(b_gnt[1]), 32'd1);
    b_req[1] = 1'b0;
    @(negedge clk);
    check("fp_rvalid1", 32'(b_rvalid[1]), 32'd1);
    @(negedge clk);
    check("fp_busy_idle", 32'(b_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
